exe_stage: RTL and testbench
============================

EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 32, which sets the number of multiply iterations (one partial product per cycle).
REQ-002 SHALL have port clk  in  1  the single clock; every register updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have ports S_UpdateSig, branch, memWriteEn, memReadEn, WB_EN  in  1 each  controls from the ID/EX pipeline register.
REQ-005 SHALL have port exeCMD  in  4  ALU operation code.
REQ-006 SHALL have ports res1, res2  in  32 each  Rn and Rm register values from the ID/EX register.
REQ-007 SHALL have port PC  in  32  the PC value carried in the ID/EX register (already PC+4).
REQ-008 SHALL have ports signedImm24  in  24, shiftOperand  in  12, isImmidiate  in  1, Dest  in  4.
REQ-009 SHALL have ports fwdSel1, fwdSel2  in  2 each  operand source: 0 = register file, 1 = MEM-stage value, 2 = WB-stage value.
REQ-010 SHALL have ports memFwdVal, wbFwdVal  in  32 each  forwarded values.
REQ-011 SHALL have ports aluRes, storeVal, brAddr  out  32 each  ALU result, store data, branch target.
REQ-012 SHALL have ports branchTaken, mulBusy  out  1 each; status  out  4  {N,Z,C,V}.
REQ-013 SHALL have ports WB_EN_out, memReadEn_out, memWriteEn_out  out  1 each; Dest_out  out  4.

Function
REQ-014 SHALL select the operands as follows: op1 = res1, memFwdVal or wbFwdVal according to fwdSel1; opM likewise from res2 according to fwdSel2; fwdSel value 3 SHALL be treated as 0.
REQ-015 SHALL generate val2 in this priority order:
- isImmidiate=1: zero-extended shiftOperand[7:0] rotated right by 2*shiftOperand[11:8].
- else memReadEn or memWriteEn: zero-extended shiftOperand[11:0].
- else: opM shifted by shiftOperand[11:7], with type from shiftOperand[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR).
REQ-016 SHALL decode exeCMD as follows:
- 0001 MOV, 1001 MVN (~val2), 0010 ADD, 0011 ADC, 0100 SUB, 0101 SBC (op1-val2-!C), 0110 AND, 0111 ORR, 1000 EOR, 1010 MUL.
- All other codes SHALL produce aluRes=0.
REQ-017 SHALL derive flags as follows:
- N = bit 31 and Z = (result==0) for every operation.
- C = carry-out, and for SUB/SBC C = NOT borrow; V = signed overflow; both only for ADD/ADC/SUB/SBC.
- All other operations SHALL leave C and V unchanged.
REQ-018 SHALL hold status in a 4-bit register updated at the clock edge only when S_UpdateSig=1, mulBusy=0 and exeCMD is not MUL, or in the MUL DONE cycle (N and Z only).
REQ-019 SHALL compute brAddr = PC + (sign-extended signedImm24 << 2), with 32-bit wrap-around; branchTaken SHALL equal branch.
REQ-020 SHALL drive storeVal = opM.
REQ-021 SHALL pass WB_EN, memReadEn, memWriteEn and Dest through to the *_out ports unchanged when mulBusy=0, and SHALL force WB_EN_out, memReadEn_out and memWriteEn_out to 0 when mulBusy=1.
REQ-022 SHALL implement the multiply state machine with states IDLE, BUSY and DONE:
- IDLE with exeCMD=MUL: capture op1 and val2, clear the accumulator, go to BUSY.
- BUSY: perform one shift-add per cycle; after MUL_CYCLES cycles go to DONE.
- DONE: go to IDLE unconditionally.
REQ-023 SHALL assert mulBusy combinationally in IDLE when exeCMD=MUL, and in BUSY, so that it is high for MUL_CYCLES+1 cycles; mulBusy SHALL be low in DONE.
REQ-024 SHALL present the low 32 bits of the product on aluRes in DONE; a MUL already present at the DONE edge SHALL not restart.
REQ-025 SHALL use the operands captured at issue for the whole multiply, so that forwarding changes during BUSY have no effect on the result.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, set status to 0000, return the state machine to IDLE, and clear the counter and accumulator, including when a multiply is in progress.
REQ-027 SHALL, while rst is high, drive mulBusy=0; all other outputs SHALL follow the combinational path from the current inputs.

Structure
REQ-028 SHALL take the exeCMD codes, fwdSel codes and shift-type codes from the shared package arm_pkg.
REQ-029 SHALL place the combinational ALU and flag logic in one sub-module, exe_alu; val2 generation, forwarding, status register and multiply state machine SHALL stay in exe_stage.

Verification
REQ-030 SHALL cover ADD with S: res1=0x7FFFFFFF, val2=1, S_UpdateSig=1 -> aluRes=0x80000000, status=1001 after the edge.
REQ-031 SHALL cover immediate rotate: isImmidiate=1, shiftOperand=0x4FF, MOV -> aluRes=0xFF000000.
REQ-032 SHALL cover forwarding: fwdSel1=1, memFwdVal=5, res1=9, SUB with val2=5 -> aluRes=0; with S_UpdateSig=1, status Z=1 and C=1.
REQ-033 SHALL cover multiply: 7 x 6 -> mulBusy high for 33 cycles, WB_EN_out low throughout, aluRes=42 with WB_EN_out=1 in the DONE cycle.
REQ-034 SHALL cover reset mid-multiply: rst in the 10th BUSY cycle -> IDLE, mulBusy=0 and status=0000 on the next cycle.
REQ-035 SHALL cover branch: PC=0x100, signedImm24=0xFFFFFE, branch=1 -> brAddr=0xF8, branchTaken=1.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared encodings for the ARM-style execute stage.
//   exeCMD codes  : ALU operation selector driven from ID/EX
//   fwdSel codes  : operand source for the forwarding muxes
//   shift types   : register-operand shift kinds in shiftOperand[6:5]
//   flags_t       : packed {N,Z,C,V} status word
package arm_pkg;

  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_MUL = 4'b1010;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef enum logic [1:0] {
    ShLsl = 2'b00,
    ShLsr = 2'b01,
    ShAsr = 2'b10,
    ShRor = 2'b11
  } shift_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // Rotate right; amt == 0 leaves x unchanged because a shift by 32 yields 0.
  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] amt);
    return (x >> amt) | (x << (6'd32 - {1'b0, amt}));
  endfunction

endpackage

// File: rtl/exe_alu.sv
// Combinational ALU and flag generation for the execute stage.
//   cmd_i      : exeCMD operation code
//   op1_i      : first operand (after forwarding)
//   val2_i     : second operand (immediate / shifted register)
//   c_i, v_i   : current C and V flags (ADC/SBC carry-in, pass-through)
//   res_o      : result (0 for MUL and undefined codes)
//   flags_o    : next {N,Z,C,V}; C and V kept unless the op is arithmetic
module exe_alu
  import arm_pkg::*;
(
  input  logic [3:0]  cmd_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] val2_i,
  input  logic        c_i,
  input  logic        v_i,
  output logic [31:0] res_o,
  output flags_t      flags_o
);

  logic [31:0] addend;
  logic        cin;
  logic        arith;
  logic [32:0] sum;

  always_comb begin
    addend = '0;
    cin    = 1'b0;
    arith  = 1'b0;
    res_o  = '0;
    case (cmd_i)
      EXE_MOV: res_o = val2_i;
      EXE_MVN: res_o = ~val2_i;
      EXE_ADD: begin arith = 1'b1; addend = val2_i;  cin = 1'b0; end
      EXE_ADC: begin arith = 1'b1; addend = val2_i;  cin = c_i;  end
      // Subtraction as op1 + ~val2 + 1; SBC folds the !C borrow into cin = C.
      EXE_SUB: begin arith = 1'b1; addend = ~val2_i; cin = 1'b1; end
      EXE_SBC: begin arith = 1'b1; addend = ~val2_i; cin = c_i;  end
      EXE_AND: res_o = op1_i & val2_i;
      EXE_ORR: res_o = op1_i | val2_i;
      EXE_EOR: res_o = op1_i ^ val2_i;
      default: res_o = '0;
    endcase

    sum = {1'b0, op1_i} + {1'b0, addend} + {32'd0, cin};
    if (arith) res_o = sum[31:0];

    flags_o.n = res_o[31];
    flags_o.z = (res_o == 32'd0);
    // Carry-out of the adder is already NOT-borrow for the subtract forms.
    flags_o.c = arith ? sum[32] : c_i;
    flags_o.v = arith ? ((op1_i[31] == addend[31]) && (sum[31] != op1_i[31])) : v_i;
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, val2 generation, ALU, status register,
// branch target and an iterative shift-add multiplier.
//   clk, rst (sync, active-high)
//   ID/EX controls : S_UpdateSig, branch, memWriteEn, memReadEn, WB_EN, exeCMD
//   ID/EX data     : res1, res2, PC, signedImm24, shiftOperand, isImmidiate, Dest
//   forwarding     : fwdSel1/2, memFwdVal, wbFwdVal
//   outputs        : aluRes, storeVal, brAddr, branchTaken, mulBusy, status,
//                    WB_EN_out, memReadEn_out, memWriteEn_out, Dest_out
module exe_stage
  import arm_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        S_UpdateSig,
  input  logic        branch,
  input  logic        memWriteEn,
  input  logic        memReadEn,
  input  logic        WB_EN,
  input  logic [3:0]  exeCMD,
  input  logic [31:0] res1,
  input  logic [31:0] res2,
  input  logic [31:0] PC,
  input  logic [23:0] signedImm24,
  input  logic [11:0] shiftOperand,
  input  logic        isImmidiate,
  input  logic [3:0]  Dest,
  input  logic [1:0]  fwdSel1,
  input  logic [1:0]  fwdSel2,
  input  logic [31:0] memFwdVal,
  input  logic [31:0] wbFwdVal,
  output logic [31:0] aluRes,
  output logic [31:0] storeVal,
  output logic [31:0] brAddr,
  output logic        branchTaken,
  output logic        mulBusy,
  output logic [3:0]  status,
  output logic        WB_EN_out,
  output logic        memReadEn_out,
  output logic        memWriteEn_out,
  output logic [3:0]  Dest_out
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int unsigned CntW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MUL_CYCLES - 1);

  logic [31:0]     op1, op_m, val2, imm_rot;
  logic [4:0]      shamt;
  logic [31:0]     alu_res;
  flags_t          alu_flags;
  logic            mul_busy;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     acc_q, acc_d;
  logic [31:0]     mcand_q, mcand_d;
  logic [31:0]     mplier_q, mplier_d;
  flags_t          status_q, status_d;

  // Operand forwarding; code 3 falls back to the register file.
  always_comb begin
    case (fwdSel1)
      FWD_MEM: op1 = memFwdVal;
      FWD_WB:  op1 = wbFwdVal;
      default: op1 = res1;
    endcase
    case (fwdSel2)
      FWD_MEM: op_m = memFwdVal;
      FWD_WB:  op_m = wbFwdVal;
      default: op_m = res2;
    endcase
  end

  // val2: immediate rotate, then load/store offset, then shifted register.
  always_comb begin
    imm_rot = ror32({24'd0, shiftOperand[7:0]}, {shiftOperand[11:8], 1'b0});
    shamt   = shiftOperand[11:7];
    val2    = op_m;
    if (isImmidiate) begin
      val2 = imm_rot;
    end else if (memReadEn || memWriteEn) begin
      val2 = {20'd0, shiftOperand};
    end else begin
      case (shift_e'(shiftOperand[6:5]))
        ShLsl: val2 = op_m << shamt;
        ShLsr: val2 = op_m >> shamt;
        ShAsr: val2 = $unsigned($signed(op_m) >>> shamt);
        ShRor: val2 = ror32(op_m, shamt);
        default: val2 = op_m;
      endcase
    end
  end

  exe_alu u_alu (
    .cmd_i   (exeCMD),
    .op1_i   (op1),
    .val2_i  (val2),
    .c_i     (status_q.c),
    .v_i     (status_q.v),
    .res_o   (alu_res),
    .flags_o (alu_flags)
  );

  // Busy covers the issue cycle plus every BUSY cycle so the pipeline stalls.
  assign mul_busy = !rst && (((state_q == ST_IDLE) && (exeCMD == EXE_MUL)) ||
                             (state_q == ST_BUSY));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    case (state_q)
      ST_IDLE: begin
        if (exeCMD == EXE_MUL) begin
          // Operands are latched here so later forwarding cannot disturb them.
          mcand_d  = op1;
          mplier_d = val2;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    status_d = status_q;
    if (state_q == ST_DONE) begin
      status_d.n = acc_q[31];
      status_d.z = (acc_q == 32'd0);
    end else if (S_UpdateSig && !mul_busy && (exeCMD != EXE_MUL)) begin
      status_d = alu_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      status_q <= status_d;
    end
  end

  assign aluRes         = (state_q == ST_DONE) ? acc_q : alu_res;
  assign storeVal       = op_m;
  assign brAddr         = PC + {{6{signedImm24[23]}}, signedImm24, 2'b00};
  assign branchTaken    = branch;
  assign mulBusy        = mul_busy;
  assign status         = status_q;
  assign WB_EN_out      = WB_EN && !mul_busy;
  assign memReadEn_out  = memReadEn && !mul_busy;
  assign memWriteEn_out = memWriteEn && !mul_busy;
  assign Dest_out       = Dest;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed scenarios plus randomized ALU
// and multiply traffic checked against an arithmetic reference model.
module tb_exe_stage;

  localparam int unsigned MulCycles = 32;
  localparam logic [3:0]  CmdMul = 4'b1010;

  logic        clk, rst;
  logic        S_UpdateSig, branch, memWriteEn, memReadEn, WB_EN;
  logic [3:0]  exeCMD;
  logic [31:0] res1, res2, PC;
  logic [23:0] signedImm24;
  logic [11:0] shiftOperand;
  logic        isImmidiate;
  logic [3:0]  Dest;
  logic [1:0]  fwdSel1, fwdSel2;
  logic [31:0] memFwdVal, wbFwdVal;
  logic [31:0] aluRes, storeVal, brAddr;
  logic        branchTaken, mulBusy;
  logic [3:0]  status;
  logic        WB_EN_out, memReadEn_out, memWriteEn_out;
  logic [3:0]  Dest_out;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [3:0] exp_status;

  exe_stage #(.MUL_CYCLES(MulCycles)) dut (
    .clk(clk), .rst(rst), .S_UpdateSig(S_UpdateSig), .branch(branch),
    .memWriteEn(memWriteEn), .memReadEn(memReadEn), .WB_EN(WB_EN), .exeCMD(exeCMD),
    .res1(res1), .res2(res2), .PC(PC), .signedImm24(signedImm24),
    .shiftOperand(shiftOperand), .isImmidiate(isImmidiate), .Dest(Dest),
    .fwdSel1(fwdSel1), .fwdSel2(fwdSel2), .memFwdVal(memFwdVal), .wbFwdVal(wbFwdVal),
    .aluRes(aluRes), .storeVal(storeVal), .brAddr(brAddr), .branchTaken(branchTaken),
    .mulBusy(mulBusy), .status(status), .WB_EN_out(WB_EN_out),
    .memReadEn_out(memReadEn_out), .memWriteEn_out(memWriteEn_out), .Dest_out(Dest_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_pick(input logic [1:0] sel, input logic [31:0] r,
                                           input logic [31:0] m, input logic [31:0] w);
    if (sel == 2'd1) return m;
    if (sel == 2'd2) return w;
    return r;
  endfunction

  function automatic logic [31:0] ref_ror(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] ref_val2(input logic imm, input logic mem,
                                           input logic [11:0] so, input logic [31:0] opm);
    int n;
    if (imm) return ref_ror({24'd0, so[7:0]}, 2 * so[11:8]);
    if (mem) return {20'd0, so};
    n = so[11:7];
    case (so[6:5])
      2'd0:    return opm << n;
      2'd1:    return opm >> n;
      2'd2:    return $unsigned($signed(opm) >>> n);
      default: return ref_ror(opm, n);
    endcase
  endfunction

  function automatic void ref_alu(input logic [3:0] cmd, input logic [31:0] a,
                                  input logic [31:0] b, input logic [3:0] fin,
                                  output logic [31:0] res, output logic [3:0] fout);
    longint ua, ub, sa, sb, full, sfull, cin, brw;
    logic c, v, arith;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    cin = fin[1] ? 1 : 0;
    brw = 1 - cin;
    full = 0; sfull = 0; arith = 1'b1;
    case (cmd)
      4'd2: begin full = ua + ub;       sfull = sa + sb;       end
      4'd3: begin full = ua + ub + cin; sfull = sa + sb + cin; end
      4'd4: begin full = ua - ub;       sfull = sa - sb;       end
      4'd5: begin full = ua - ub - brw; sfull = sa - sb - brw; end
      default: arith = 1'b0;
    endcase
    c = fin[1]; v = fin[0];
    if (arith) begin
      res = full[31:0];
      if (cmd == 4'd2 || cmd == 4'd3) c = (full > 64'sh0_FFFF_FFFF);
      else c = (full >= 0);
      v = (sfull > 64'sh7FFF_FFFF) || (sfull < -64'sh8000_0000);
    end else begin
      case (cmd)
        4'd1:    res = b;
        4'd9:    res = ~b;
        4'd6:    res = a & b;
        4'd7:    res = a | b;
        4'd8:    res = a ^ b;
        default: res = 32'd0;
      endcase
    end
    fout = {res[31], res == 32'd0, c, v};
  endfunction

  // One non-multiply instruction: check combinational outputs, clock, check status.
  task automatic step(input string tag);
    logic [31:0] a, m, v2, er, off;
    logic [3:0]  ef;
    a  = ref_pick(fwdSel1, res1, memFwdVal, wbFwdVal);
    m  = ref_pick(fwdSel2, res2, memFwdVal, wbFwdVal);
    v2 = ref_val2(isImmidiate, memReadEn | memWriteEn, shiftOperand, m);
    ref_alu(exeCMD, a, v2, exp_status, er, ef);
    off = 32'($signed(signedImm24));
    #1;
    chk({tag, ":aluRes"}, aluRes, er);
    chk({tag, ":storeVal"}, storeVal, m);
    chk({tag, ":brAddr"}, brAddr, PC + off * 32'd4);
    chk({tag, ":branchTaken"}, branchTaken, branch);
    chk({tag, ":mulBusy"}, mulBusy, 0);
    chk({tag, ":wb_out"}, WB_EN_out, WB_EN);
    chk({tag, ":rd_out"}, memReadEn_out, memReadEn);
    chk({tag, ":wr_out"}, memWriteEn_out, memWriteEn);
    chk({tag, ":dest_out"}, Dest_out, Dest);
    @(posedge clk); #1;
    if (S_UpdateSig && exeCMD != CmdMul) exp_status = ef;
    chk({tag, ":status"}, status, exp_status);
  endtask

  task automatic randomize_inputs();
    S_UpdateSig  = 1'($urandom);
    branch       = 1'($urandom);
    memReadEn    = ($urandom_range(0, 3) == 0);
    memWriteEn   = ($urandom_range(0, 3) == 0);
    WB_EN        = 1'($urandom);
    exeCMD       = 4'($urandom);
    if (exeCMD == CmdMul) exeCMD = 4'd2;
    res1         = $urandom;
    res2         = $urandom;
    PC           = $urandom;
    signedImm24  = 24'($urandom);
    shiftOperand = 12'($urandom);
    isImmidiate  = 1'($urandom);
    Dest         = 4'($urandom);
    fwdSel1      = 2'($urandom);
    fwdSel2      = 2'($urandom);
    memFwdVal    = $urandom;
    wbFwdVal     = $urandom;
  endtask

  // Issue a MUL with the inputs currently set; scramble forwarding during BUSY.
  task automatic run_mul(input string tag);
    logic [31:0] a, v2, prod;
    logic [63:0] full;
    int busy;
    exeCMD     = CmdMul;
    WB_EN      = 1'b1;
    memReadEn  = 1'b0;
    memWriteEn = 1'b0;
    a    = ref_pick(fwdSel1, res1, memFwdVal, wbFwdVal);
    v2   = ref_val2(isImmidiate, 1'b0, shiftOperand,
                    ref_pick(fwdSel2, res2, memFwdVal, wbFwdVal));
    full = {32'd0, a} * {32'd0, v2};
    prod = full[31:0];
    #1;
    busy = 0;
    while (mulBusy === 1'b1 && busy < 100) begin
      if (WB_EN_out !== 1'b0) chk({tag, ":wb_forced"}, WB_EN_out, 0);
      @(posedge clk); #1;
      busy++;
      res1 = $urandom; res2 = $urandom; memFwdVal = $urandom; wbFwdVal = $urandom;
      fwdSel1 = 2'($urandom); fwdSel2 = 2'($urandom);
    end
    chk({tag, ":busy_cycles"}, busy, MulCycles + 1);
    chk({tag, ":product"}, aluRes, prod);
    chk({tag, ":wb_done"}, WB_EN_out, 1);
    chk({tag, ":busy_done"}, mulBusy, 0);
    @(posedge clk); #1;
    exeCMD      = 4'd6;
    S_UpdateSig = 1'b0;
    exp_status  = {prod[31], prod == 32'd0, exp_status[1:0]};
    #1;
    chk({tag, ":status"}, status, exp_status);
    chk({tag, ":idle_again"}, mulBusy, 0);
  endtask

  initial begin
    rst = 1'b1; S_UpdateSig = 1'b1; branch = 1'b0; memWriteEn = 1'b0; memReadEn = 1'b0;
    WB_EN = 1'b0; exeCMD = CmdMul; res1 = 32'd3; res2 = 32'd4; PC = '0; signedImm24 = '0;
    shiftOperand = 12'h001; isImmidiate = 1'b1; Dest = 4'd0; fwdSel1 = 2'd0;
    fwdSel2 = 2'd0; memFwdVal = '0; wbFwdVal = '0;
    exp_status = 4'b0000;

    // Reset: mulBusy suppressed even with MUL presented.
    #1;
    chk("rst:mulBusy", mulBusy, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst:status", status, 4'b0000);
    rst = 1'b0;
    exeCMD = 4'd0;
    S_UpdateSig = 1'b0;

    // Immediate rotate: 0xFF ror 8.
    isImmidiate = 1'b1; shiftOperand = 12'h4FF; exeCMD = 4'd1;
    step("imm_rot");
    chk("imm_rot:const", aluRes, 32'hFF00_0000);

    // Forwarded SUB to zero.
    fwdSel1 = 2'd1; memFwdVal = 32'd5; res1 = 32'd9; shiftOperand = 12'h005;
    exeCMD = 4'd4; S_UpdateSig = 1'b1;
    step("fwd_sub");
    chk("fwd_sub:const", aluRes, 32'd0);
    chk("fwd_sub:zc", status[2:1], 2'b11);

    // Backward branch.
    PC = 32'h100; signedImm24 = 24'hFFFFFE; branch = 1'b1; S_UpdateSig = 1'b0;
    step("branch");
    chk("branch:const", brAddr, 32'hF8);
    chk("branch:taken", branchTaken, 1);

    // Randomized non-multiply traffic.
    for (int i = 0; i < 200; i++) begin
      randomize_inputs();
      step("rand");
    end

    // 7 x 6 multiply.
    randomize_inputs();
    fwdSel1 = 2'd0; res1 = 32'd7; isImmidiate = 1'b1; shiftOperand = 12'h006;
    run_mul("mul7x6");

    // Random multiplies, including register-shifted multiplier.
    for (int i = 0; i < 4; i++) begin
      randomize_inputs();
      run_mul("mul_rand");
    end

    // ADD overflow sets N and V.
    randomize_inputs();
    fwdSel1 = 2'd0; res1 = 32'h7FFF_FFFF; isImmidiate = 1'b1; shiftOperand = 12'h001;
    memReadEn = 1'b0; memWriteEn = 1'b0; exeCMD = 4'd2; S_UpdateSig = 1'b1;
    step("add_ovf");
    chk("add_ovf:const", aluRes, 32'h8000_0000);
    chk("add_ovf:status", status, 4'b1001);

    // Reset in the 10th BUSY cycle.
    exeCMD = CmdMul; S_UpdateSig = 1'b0; res1 = 32'd11;
    #1;
    chk("midrst:issue", mulBusy, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("midrst:busy10", mulBusy, 1);
    rst = 1'b1;
    #1;
    chk("midrst:busy_in_rst", mulBusy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exeCMD = 4'd6;
    exp_status = 4'b0000;
    #1;
    chk("midrst:busy_after", mulBusy, 0);
    chk("midrst:status", status, 4'b0000);

    // A full multiply right after the abort must take the full length.
    randomize_inputs();
    run_mul("mul_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
